// File: rtl/mult_datapath.sv
// Datapath for the 32-bit shift-and-add multiplier: operand, accumulator and product registers
// driven by the control unit's strobes. Define MULT_SIGNED_EN for two's-complement operation.
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift_l,
    input  logic                 shift_r,
    input  logic                 write,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 M0,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_reg, mcand_next, mcand_shl;
    logic [PW-1:0]    acc_reg, acc_next;
    logic [PW-1:0]    product_reg, product_next, result;
    logic [WIDTH-1:0] mplier_reg, mplier_next, mplier_shr;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             product_valid_reg, product_valid_next;
    logic             done_reg, done_next;

    // Zero-fill shifted copies of the operand registers.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_shl
            if (gi == 0) begin : g_lsb
                assign mcand_shl[gi] = 1'b0;
            end else begin : g_bit
                assign mcand_shl[gi] = mcand_reg[gi-1];
            end
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_shr
            if (gi == WIDTH - 1) begin : g_msb
                assign mplier_shr[gi] = 1'b0;
            end else begin : g_bit
                assign mplier_shr[gi] = mplier_reg[gi+1];
            end
        end
    endgenerate

`ifdef MULT_SIGNED_EN
    logic sign_reg, sign_next;

    // Negating the most negative value wraps to itself, which reads correctly as unsigned.
    assign a_mag     = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag     = b_in[WIDTH-1] ? -b_in : b_in;
    assign result    = sign_reg ? -acc_reg : acc_reg;
    assign sign_next = load ? (a_in[WIDTH-1] ^ b_in[WIDTH-1]) : sign_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_reg <= 1'b0;
        end else begin
            sign_reg <= sign_next;
        end
    end
`else
    assign a_mag  = a_in;
    assign b_mag  = b_in;
    assign result = acc_reg;
`endif

    always_comb begin
        mcand_next         = mcand_reg;
        mplier_next        = mplier_reg;
        acc_next           = acc_reg;
        product_next       = product_reg;
        product_valid_next = product_valid_reg;
        done_next          = valid && !load;

        if (load) begin
            mcand_next         = {{WIDTH{1'b0}}, a_mag};
            mplier_next        = b_mag;
            acc_next           = '0;
            product_valid_next = 1'b0;
        end else begin
            // The add always uses the pre-shift multiplicand.
            if (write) begin
                acc_next = acc_reg + mcand_reg;
            end
            if (shift_l) begin
                mcand_next = mcand_shl;
            end
            if (shift_r) begin
                mplier_next = mplier_shr;
            end
            if (valid) begin
                product_next       = result;
                product_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg         <= '0;
            mplier_reg        <= '0;
            acc_reg           <= '0;
            product_reg       <= '0;
            product_valid_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            mcand_reg         <= mcand_next;
            mplier_reg        <= mplier_next;
            acc_reg           <= acc_next;
            product_reg       <= product_next;
            product_valid_reg <= product_valid_next;
            done_reg          <= done_next;
        end
    end

    assign M0            = mplier_reg[0];
    assign product       = product_reg;
    assign product_valid = product_valid_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: emulates the control unit and checks against an arithmetic model.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        reset, load, shift_l, shift_r, write, valid;
    logic [31:0] a_in, b_in;
    logic        M0;
    logic [63:0] product;
    logic        product_valid, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_prod, pend_prod, last_exp;
    logic        exp_pv, exp_done;

    always #5 clk = ~clk;

    mult_datapath #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .load(load), .shift_l(shift_l), .shift_r(shift_r),
        .write(write), .valid(valid), .a_in(a_in), .b_in(b_in), .M0(M0),
        .product(product), .product_valid(product_valid), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    function automatic logic [31:0] eff_b(input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        return b[31] ? -b : b;
`else
        return b;
`endif
    endfunction

    // Transaction-level model: a load arms a*b, a valid publishes it.
    always @(posedge clk) begin
        if (reset) begin
            exp_prod = '0; exp_pv = 1'b0; exp_done = 1'b0; pend_prod = '0;
        end else if (load) begin
            exp_pv = 1'b0; exp_done = 1'b0; pend_prod = ref_mul(a_in, b_in);
        end else if (valid) begin
            exp_prod = pend_prod; exp_pv = 1'b1; exp_done = 1'b1;
        end else begin
            exp_done = 1'b0;
        end
        #1;
        chk("product", product, exp_prod);
        chk("product_valid", {63'b0, product_valid}, {63'b0, exp_pv});
        chk("done", {63'b0, done}, {63'b0, exp_done});
    end

    task automatic idle();
        load = 0; shift_l = 0; shift_r = 0; write = 0; valid = 0;
    endtask

    // Drives one full control-unit sequence; abort_at >= 0 fires reset at that iteration.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int abort_at,
                          output int lat, output logic [63:0] res);
        logic [31:0] bm;
        int nwrite;
        bm = eff_b(b);
        nwrite = 0;
        lat = 0;
        @(negedge clk);
        idle(); load = 1; a_in = a; b_in = b;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle(); lat++;
            chk("M0", {63'b0, M0}, {63'b0, bm[i]});
            if (i == 0) begin
                chk("hold_product_after_load", product, last_exp);
                chk("pv_cleared_after_load", {63'b0, product_valid}, 64'd0);
            end
            if (i == abort_at) begin
                reset = 1;
                #1;
                chk("reset_M0", {63'b0, M0}, 64'd0);
                chk("reset_product", product, 64'd0);
                chk("reset_pv", {63'b0, product_valid}, 64'd0);
                chk("reset_done", {63'b0, done}, 64'd0);
                @(negedge clk);
                reset = 0;
                last_exp = '0;
                res = '0;
                $display("op a=%h b=%h reset at iteration %0d", a, b, i);
                return;
            end
            if (M0) begin
                @(negedge clk); write = 1; lat++; nwrite++;
            end
            @(negedge clk); idle(); shift_l = 1; shift_r = 1; lat++;
        end
        @(negedge clk); idle(); valid = 1; lat++;
        @(negedge clk); idle();
        res = product;
        chk("latency", 64'(lat), 64'(65 + $countones(bm)));
        chk("write_count", 64'(nwrite), 64'($countones(bm)));
        last_exp = ref_mul(a, b);
        $display("op a=%h b=%h product=%h latency=%0d", a, b, product, lat);
    endtask

    initial begin
        int lat;
        logic [63:0] res;
        logic [31:0] ra, rb;
        last_exp = '0;
        reset = 1; a_in = '0; b_in = '0;
        idle();
        repeat (3) @(negedge clk);
        reset = 0;

`ifdef MULT_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, -1, lat, res);
        chk("lit_neg3x5", res, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, lat, res);
        chk("lit_min_x_neg1", res, 64'h0000_0000_8000_0000);
        chk("lit_min_x_neg1_lat", 64'(lat), 64'd66);
`else
        run_op(32'd3, 32'd5, -1, lat, res);
        chk("lit_3x5", res, 64'h0000_0000_0000_000F);
        chk("lit_3x5_lat", 64'(lat), 64'd67);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, res);
        chk("lit_ffxff", res, 64'hFFFF_FFFE_0000_0001);
        chk("lit_ffxff_lat", 64'(lat), 64'd97);
        run_op(32'h1234_5678, 32'd0, -1, lat, res);
        chk("lit_bzero", res, 64'd0);
        chk("lit_bzero_lat", 64'(lat), 64'd65);
`endif
        run_op(32'd7, 32'd9, 10, lat, res);
        run_op(32'd7, 32'd9, -1, lat, res);
        chk("lit_7x9", res, 64'd63);
        run_op(32'd3, 32'd5, -1, lat, res);
        chk("lit_3x5_again", res, 64'd15);
        run_op(32'd2, 32'd2, -1, lat, res);
        chk("lit_2x2", res, 64'd4);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 7 == 3) rb = 32'd0;
            if (k % 7 == 5) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, (k % 9 == 4) ? int'($urandom_range(0, 31)) : -1, lat, res);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
